alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid_i  input  1  requester N (N=0,1) holds a valid operation.
REQ-005 reqN_ready_o  output  1  arbiter accepts requester N operation this cycle.
REQ-006 reqN_comp_sel_i  input  3  requester N compare select (ALU_COMP_* encoding).
REQ-007 reqN_op_0_sel_i  input  1  requester N op-0 select (sub/sra modifier).
REQ-008 reqN_op_1_sel_i  input  3  requester N op-1 select (ALU_OP_1_* encoding).
REQ-009 reqN_a_comp_i, reqN_b_comp_i  input  XLEN each  requester N compare operands.
REQ-010 reqN_a_data_i, reqN_b_data_i  input  XLEN each  requester N data operands.
REQ-011 rspN_valid_o  output  1  result for requester N available.
REQ-012 rspN_ready_i  input  1  requester N consumes result.
REQ-013 rspN_comp_o  output  1  compare result returned to requester N.
REQ-014 rspN_data_o  output  XLEN  data result returned to requester N.
REQ-015 alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o  output  3/1/3  registered selects to shared ALU.
REQ-016 alu_a_comp_o, alu_b_comp_o, alu_a_data_o, alu_b_data_o  output  XLEN each  registered operands to shared ALU.
REQ-017 alu_comp_i  input  1  / alu_data_i  input  XLEN  combinational results from shared ALU.

Function
REQ-018 FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-019 In IDLE, reqN_ready_o SHALL be 1 only for the arbitration winner; it is 0 in EXEC and RESP.
REQ-020 Handshake SHALL occur when reqN_valid_i & reqN_ready_o; only one requester is granted per cycle.
REQ-021 On handshake, selects and operands SHALL be registered onto alu_* outputs, the owner index SHALL be stored, and the FSM SHALL go to EXEC.
REQ-022 In EXEC, alu_comp_i/alu_data_i SHALL be captured into response registers and the FSM SHALL go to RESP.
REQ-023 In RESP, rsp<owner>_valid_o SHALL be 1 and the other rsp valid 0; response data SHALL remain stable until rsp<owner>_ready_i is high.
REQ-024 On RESP with rsp<owner>_ready_i high, FSM SHALL return to IDLE; the next grant is possible in that following IDLE cycle.
REQ-025 Latency: handshake at cycle T yields rsp valid at T+2; minimum issue interval 3 cycles.
REQ-026 alu_* outputs SHALL hold their last registered values outside handshake cycles.
REQ-027 rspN_comp_o/rspN_data_o SHALL both present the response registers; only valid is qualified by owner.
REQ-028 Requests with valid low SHALL never be granted; no valid in IDLE keeps FSM in IDLE.
REQ-029 Requester whose valid drops before handshake SHALL lose nothing; no state changes.

Reset
REQ-030 With rst_n_i low at a clock edge: FSM to IDLE, reqN_ready_o=0 for that cycle, rspN_valid_o=0, response registers 0, all alu_* outputs 0, priority pointer to reset value.
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight operation without emitting a response.

Configuration
REQ-032 Macro ALU_ARB_RR_EN defined: round-robin; 1-bit pointer holds last granted index, resets to 1 (req0 wins first contention), updates on each handshake; when both valid, the non-last requester wins.
REQ-033 ALU_ARB_RR_EN undefined: fixed priority, req0 always wins when both valid; pointer logic absent.
REQ-034 A single valid requester SHALL be granted in either configuration.

Verification
REQ-035 req0 only, op_1=ADD, op_0=1, a_data=10, b_data=3 -> req0_ready=1 at T, rsp0_valid at T+2, rsp0_data=7, rsp1_valid=0.
REQ-036 req1 only, comp_sel=BLTU, a_comp=1, b_comp=0xFFFFFFFF -> rsp1_comp=1 at T+2.
REQ-037 Both valid continuously, RR enabled -> grants req0, req1, req0, req1; RR disabled -> req0 every grant.
REQ-038 rsp0_ready_i held low 5 cycles in RESP -> rsp0_valid and rsp0_data stable 5 cycles, req ready 0 throughout, IDLE after ready.
REQ-039 rst_n_i low during EXEC -> next cycle all rsp valid 0, alu_* 0, FSM IDLE; no response for the dropped op.
REQ-040 op_1=SRL, op_0=1, a_data=0x80000000, b_data=4 -> rsp_data=0xF8000000.

Source files
------------

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Each accepted operation takes three cycles: IDLE (grant), EXEC (ALU evaluates the
// registered operands), RESP (result held until the owner accepts it).
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority.
module alu_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  // requester 0
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [2:0]      req0_comp_sel_i,
  input  logic            req0_op_0_sel_i,
  input  logic [2:0]      req0_op_1_sel_i,
  input  logic [XLEN-1:0] req0_a_comp_i,
  input  logic [XLEN-1:0] req0_b_comp_i,
  input  logic [XLEN-1:0] req0_a_data_i,
  input  logic [XLEN-1:0] req0_b_data_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic            rsp0_comp_o,
  output logic [XLEN-1:0] rsp0_data_o,
  // requester 1
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [2:0]      req1_comp_sel_i,
  input  logic            req1_op_0_sel_i,
  input  logic [2:0]      req1_op_1_sel_i,
  input  logic [XLEN-1:0] req1_a_comp_i,
  input  logic [XLEN-1:0] req1_b_comp_i,
  input  logic [XLEN-1:0] req1_a_data_i,
  input  logic [XLEN-1:0] req1_b_data_i,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic            rsp1_comp_o,
  output logic [XLEN-1:0] rsp1_data_o,
  // shared ALU
  output logic [2:0]      alu_comp_sel_o,
  output logic            alu_op_0_sel_o,
  output logic [2:0]      alu_op_1_sel_o,
  output logic [XLEN-1:0] alu_a_comp_o,
  output logic [XLEN-1:0] alu_b_comp_o,
  output logic [XLEN-1:0] alu_a_data_o,
  output logic [XLEN-1:0] alu_b_data_o,
  input  logic            alu_comp_i,
  input  logic [XLEN-1:0] alu_data_i
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            gnt0, gnt1, handshake;
  logic            rsp_comp_q;
  logic [XLEN-1:0] rsp_data_q;

  logic [2:0]      comp_sel_q, op_1_sel_q;
  logic            op_0_sel_q;
  logic [XLEN-1:0] a_comp_q, b_comp_q, a_data_q, b_data_q;

`ifdef ALU_ARB_RR_EN
  // Index of the most recently granted requester.
  logic last_q;

  // Pointer starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (handshake) begin
      last_q <= gnt1;
    end
  end
`endif

  // Grant only in IDLE and never while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n_i && (state_q == StIdle)) begin
      if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_RR_EN
        gnt0 = last_q;
        gnt1 = ~last_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
    end
  end

  assign handshake    = gnt0 | gnt1;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Next-state logic: owner is latched on grant and released when it takes the result.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StExec;
          owner_d = gnt1;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and owner registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Operand/select registers feeding the ALU; they hold between grants.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      comp_sel_q <= '0;
      op_0_sel_q <= 1'b0;
      op_1_sel_q <= '0;
      a_comp_q   <= '0;
      b_comp_q   <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
    end else if (handshake) begin
      comp_sel_q <= gnt1 ? req1_comp_sel_i : req0_comp_sel_i;
      op_0_sel_q <= gnt1 ? req1_op_0_sel_i : req0_op_0_sel_i;
      op_1_sel_q <= gnt1 ? req1_op_1_sel_i : req0_op_1_sel_i;
      a_comp_q   <= gnt1 ? req1_a_comp_i   : req0_a_comp_i;
      b_comp_q   <= gnt1 ? req1_b_comp_i   : req0_b_comp_i;
      a_data_q   <= gnt1 ? req1_a_data_i   : req0_a_data_i;
      b_data_q   <= gnt1 ? req1_b_data_i   : req0_b_data_i;
    end
  end

  // Capture the ALU result one cycle after issue.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_comp_q <= 1'b0;
      rsp_data_q <= '0;
    end else if (state_q == StExec) begin
      rsp_comp_q <= alu_comp_i;
      rsp_data_q <= alu_data_i;
    end
  end

  assign alu_comp_sel_o = comp_sel_q;
  assign alu_op_0_sel_o = op_0_sel_q;
  assign alu_op_1_sel_o = op_1_sel_q;
  assign alu_a_comp_o   = a_comp_q;
  assign alu_b_comp_o   = b_comp_q;
  assign alu_a_data_o   = a_data_q;
  assign alu_b_data_o   = b_data_q;

  // Both requesters see the result registers; only valid is steered by owner.
  assign rsp0_valid_o = (state_q == StResp) && !owner_q;
  assign rsp1_valid_o = (state_q == StResp) &&  owner_q;
  assign rsp0_comp_o  = rsp_comp_q;
  assign rsp1_comp_o  = rsp_comp_q;
  assign rsp0_data_o  = rsp_data_q;
  assign rsp1_data_o  = rsp_data_q;

endmodule
